apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

APB requester that converts a simple valid/ready command stream into single APB3 read/write transfers and returns one response per command. It sits between the processor-side core logic and the APB peripheral bus (GPIO/UART register slaves at 0x1000/0x1004/0x1008). It inserts unlimited PREADY wait states, aborts hung transfers on a configurable timeout, and rejects unaligned addresses without touching the bus.

## Interface
- PADDR_SIZE, 32, address width
- PDATA_SIZE, 32, data width (multiple of 8)
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables timeout
- PCLK  in  1  single clock, all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at PCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  PADDR_SIZE  byte address
- cmd_wdata  in  PDATA_SIZE  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at PCLK edge
- rsp_rdata  out  PDATA_SIZE  read data (0 for writes and errors)
- rsp_err  out  1  1 = timeout or unaligned address
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  PADDR_SIZE  APB address
- PWDATA  out  PDATA_SIZE  APB write data
- PRDATA  in  PDATA_SIZE  APB read data
- PREADY  in  1  APB transfer complete

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1 (0 while PRESET high). On accept: latch cmd_write/addr/wdata; if cmd_addr[1:0]!=0 go RESP with rsp_err=1, rsp_rdata=0, no APB activity; else drive PADDR/PWRITE/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0, one cycle, then ACCESS; timeout counter cleared.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1 sampled: capture PRDATA into rsp_rdata if read (0 if write), rsp_err=0, go RESP. PREADY=0: increment counter; when counter reaches TIMEOUT_CYCLES (nonzero) go RESP with rsp_err=1, rsp_rdata=0.
- RESP: PSEL=PENABLE=0, rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready=1, then IDLE.
- PADDR/PWRITE/PWDATA hold last values outside transfers; stable from SETUP through end of ACCESS.
- Counter saturates; width = clog2(TIMEOUT_CYCLES+1), min 1.
- One outstanding command; no new accept until response consumed.

## Timing
- Reset (PRESET high at edge): state IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0; cmd_ready=0 during reset.
- Reset mid-transfer (any state): next edge all outputs to reset values, transfer dropped, no response issued.
- Accept at edge N → SETUP cycle N+1 → ACCESS N+2 → with zero wait states rsp_valid high from N+3.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Unaligned: accept at N → rsp_valid from N+1.
- rsp_ready=1 at first RESP edge → IDLE next cycle; earliest next accept 1 cycle after that (min 5 cycles/transfer).
- PREADY ignored outside ACCESS; cmd_* ignored outside IDLE.
- Timeout and PREADY=1 same edge: PREADY wins (normal completion).

## Test plan
- Write 0xDEADBEEF to 0x1004, slave PREADY=1 → PSEL N+1, PENABLE N+2, PWRITE=1, PWDATA=0xDEADBEEF, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read 0x1008 after reset slave (value 0xF1), PREADY held 0 for 3 ACCESS cycles → PENABLE high 4 cycles, rsp_rdata=0x000000F1 at N+6, rsp_err=0.
- TIMEOUT_CYCLES=4, slave PREADY stuck 0 → after 4 ACCESS cycles PSEL/PENABLE drop, rsp_err=1, rsp_rdata=0.
- Read 0x1002 → no PSEL ever, rsp_valid at N+1, rsp_err=1.
- rsp_ready held 0 for 5 cycles after completion, cmd_valid held 1 → rsp stable, cmd_ready=0 throughout; second command accepted one cycle after rsp_ready pulse.
- PRESET pulsed during ACCESS → next edge PSEL=PENABLE=0, rsp_valid stays 0, cmd_ready=1 after PRESET falls.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns a valid/ready command stream into single APB transfers
// and returns one response per command. Handles unlimited PREADY wait states,
// aborts hung transfers after TIMEOUT_CYCLES, rejects unaligned addresses.
module apb_master_bridge #(
  parameter int unsigned PADDR_SIZE     = 32,
  parameter int unsigned PDATA_SIZE     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [PADDR_SIZE-1:0] cmd_addr,
  input  logic [PDATA_SIZE-1:0] cmd_wdata,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  // APB requester side
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [PADDR_SIZE-1:0] PADDR,
  output logic [PDATA_SIZE-1:0] PWDATA,
  input  logic [PDATA_SIZE-1:0] PRDATA,
  input  logic                  PREADY
);

  // TIMEOUT_CYCLES == 0 still needs a 1-bit counter
  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax     = '1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic [PDATA_SIZE-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       cnt_inc;

  // Next-state logic: sequencing, address/data capture, timeout and response
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_addr[1:0] != 2'b00) begin
            // Unaligned: answer with an error, never touch the bus
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_wdata;
            state_d  = StSetup;
          end
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        // PREADY takes priority over an expiring timeout
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TimeoutVal)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    cmd_ready = (state_q == StIdle) && !PRESET;
    PSEL      = (state_q == StSetup) || (state_q == StAccess);
    PENABLE   = (state_q == StAccess);
    rsp_valid = (state_q == StResp);
    PADDR     = paddr_q;
    PWRITE    = pwrite_q;
    PWDATA    = pwdata_q;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed + random commands against a
// timeline model (each command becomes a window of SETUP/ACCESS/RESP cycles).
module tb_apb_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_master_bridge #(
    .PADDR_SIZE    (AW),
    .PDATA_SIZE    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          w;     // wait states the slave inserts
    int          rdly;  // cycles the consumer stalls the response
    int          roff;  // reset pulse this many cycles after accept (0 = none)
  } plan_t;

  plan_t plans[$];
  plan_t cur;

  int checks   = 0;
  int failures = 0;
  int c        = 0;

  // model state
  bit          busy, al, after_reset, in_acc;
  int          a, k, rs, pi, rc, rd_cnt, cur_ix, lat, pen_cnt, last_cons;
  logic [31:0] exp_data;
  bit          exp_err;
  logic [31:0] mem [16];
  logic [31:0] seen_rdata;
  bit          seen_err;
  bit          exp_ready, exp_psel, exp_pen, exp_rv;

  // hand-computed expectations for directed commands 0..4
  int          lit_lat [5] = '{3, 6, 6, 1, 3};
  int          lit_pen [5] = '{1, 4, 4, 0, 1};
  logic [31:0] lit_rd  [5] = '{32'h0, 32'hF1, 32'h0, 32'h0, 32'hDEADBEEF};
  bit          lit_err [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%08h expected=0x%08h", name, c, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input int w, input int rdly, input int roff);
    plan_t p;
    p.wr = wr; p.addr = addr; p.wdata = wd; p.w = w; p.rdly = rdly; p.roff = roff;
    plans.push_back(p);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[2] = 32'hF1;

    // directed
    add(1'b1, 32'h1004, 32'hDEADBEEF, 0,    0, 0);
    add(1'b0, 32'h1008, 32'h0,        3,    0, 0);
    add(1'b0, 32'h1000, 32'h0,        1000, 0, 0);
    add(1'b0, 32'h1002, 32'h0,        0,    0, 0);
    add(1'b0, 32'h1004, 32'h0,        0,    5, 0);
    add(1'b0, 32'h100C, 32'h0,        1000, 0, 3);
    // random
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ad;
      int          w;
      ad = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) ad = ad + 32'($urandom_range(1, 3));
      w = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
      add(1'($urandom_range(0, 1)), ad, $urandom, w, int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 8)) : 0);
    end

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0;
    busy = 1'b0; after_reset = 1'b1; rc = -1; pi = 0; last_cons = -100;
    a = 0; k = 0; rs = 0; al = 1'b0; rd_cnt = 0; lat = -1; pen_cnt = 0; cur_ix = 0;

    while ((pi < plans.size() || busy) && c < 20000) begin
      @(posedge PCLK);
      c++;
      #1;
      // drive inputs for this cycle
      PRESET = (c <= 3) || (c == rc);
      if (pi < plans.size()) begin
        cmd_valid = (pi < 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
        cmd_write = plans[pi].wr;
        cmd_addr  = plans[pi].addr;
        cmd_wdata = plans[pi].wdata;
      end else begin
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
      end
      in_acc = busy && al && (c >= a + 2) && (c <= a + 1 + k);
      if (in_acc) begin
        PREADY = (c == a + 2 + cur.w);
        PRDATA = (PREADY && !cur.wr) ? mem[cur.addr[5:2]] : $urandom;
        if (PREADY && cur.wr && !PRESET) mem[cur.addr[5:2]] = cur.wdata;
      end else begin
        PREADY = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
      end
      if (busy && c >= rs) rsp_ready = (rd_cnt >= cur.rdly);
      else                 rsp_ready = 1'($urandom_range(0, 1));

      @(negedge PCLK);
      // compare against the timeline model
      exp_ready = !busy && !PRESET;
      exp_psel  = busy && al && (c >= a + 1) && (c <= a + 1 + k);
      exp_pen   = busy && al && (c >= a + 2) && (c <= a + 1 + k);
      exp_rv    = busy && (c >= rs);
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      chk("PSEL",      32'(PSEL),      32'(exp_psel));
      chk("PENABLE",   32'(PENABLE),   32'(exp_pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_psel) begin
        chk("PADDR",  PADDR,         cur.addr);
        chk("PWRITE", 32'(PWRITE),   32'(cur.wr));
        if (cur.wr) chk("PWDATA", PWDATA, cur.wdata);
      end
      if (exp_rv) begin
        chk("rsp_rdata", rsp_rdata,    exp_data);
        chk("rsp_err",   32'(rsp_err), 32'(exp_err));
      end
      if (after_reset) begin
        chk("rst_PADDR",     PADDR,          32'h0);
        chk("rst_PWDATA",    PWDATA,         32'h0);
        chk("rst_PWRITE",    32'(PWRITE),    32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
      end
      if (busy) begin
        if (PENABLE) pen_cnt++;
        if (rsp_valid && lat < 0) begin
          lat = c - a; seen_rdata = rsp_rdata; seen_err = rsp_err;
        end
      end

      // advance the model across the coming edge
      if (PRESET) begin
        busy = 1'b0;
        after_reset = 1'b1;
      end else if (!busy && cmd_valid) begin
        cur = plans[pi]; cur_ix = pi; pi++;
        a = c; al = (cur.addr[1:0] == 2'b00);
        if (cur_ix == 5) chk("accept_after_rsp", 32'(a - last_cons), 32'd1);
        if (!al) begin
          k = 0; rs = a + 1; exp_err = 1'b1; exp_data = '0;
        end else if (cur.w >= int'(TO)) begin
          k = int'(TO); rs = a + 2 + k; exp_err = 1'b1; exp_data = '0;
        end else begin
          k = cur.w + 1; rs = a + 2 + k; exp_err = 1'b0;
          exp_data = cur.wr ? 32'h0 : mem[cur.addr[5:2]];
        end
        busy = 1'b1; after_reset = 1'b0; rd_cnt = 0; lat = -1; pen_cnt = 0;
        rc = (cur.roff > 0) ? a + cur.roff : -1;
      end else if (busy && c >= rs) begin
        if (rsp_ready) begin
          busy = 1'b0;
          last_cons = c;
          if (cur_ix < 5) begin
            chk("dir_latency", 32'(lat),      32'(lit_lat[cur_ix]));
            chk("dir_penable", 32'(pen_cnt),  32'(lit_pen[cur_ix]));
            chk("dir_rdata",   seen_rdata,    lit_rd[cur_ix]);
            chk("dir_err",     32'(seen_err), 32'(lit_err[cur_ix]));
          end
        end else begin
          rd_cnt++;
        end
      end
    end

    if (busy || pi < plans.size()) begin
      failures++;
      $display("FAIL run_bound cycle=%0d actual=%0d_cmds expected=%0d_cmds", c, pi, plans.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
